// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Consumed by seg_tick_prescaler and seg_scan_controller.
package seg_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } seg_state_e;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Index 0 is digit1, the rightmost digit, which sits in load bits [3:0].
    typedef logic [3:0][3:0] seg_digits_t;

    function automatic logic [3:0] anode_pattern(input logic [1:0] sel);
        anode_pattern = ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/seg_tick_prescaler.sv
// Free-running divider that emits a one-cycle scan tick every CLK_DIV clocks.
module seg_tick_prescaler #(
    parameter int CLK_DIV = 25000
) (
    input  logic clock,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == CW'(CLK_DIV - 1));

    always_comb begin
        count_d = tick ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan sequencer with a double-buffered digit register.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (suppress leading zeros on digits 4..2).
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int CLK_DIV     = 25000,
    parameter int ON_TICKS    = 3,
    parameter int GUARD_TICKS = 1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_digits,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  anode,
    output logic [1:0]  digit_sel,
    output logic [3:0]  one_digit,
    output logic        digit_blank,
    output logic        frame_done,
    output seg_state_e  dbg_state
);

    localparam int TMAX = (ON_TICKS > GUARD_TICKS) ? ON_TICKS : GUARD_TICKS;
    localparam int TCW  = (TMAX > 1) ? $clog2(TMAX) : 1;

    logic tick;

    seg_tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clock (clock),
        .rst   (rst),
        .tick  (tick)
    );

    seg_state_e  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic        boundary;

    seg_digits_t active_q, active_d;
    seg_digits_t pend_q, pend_d;
    logic        pend_full_q, pend_full_d;

    logic [3:0]  anode_q, anode_d;
    logic [3:0]  one_digit_q, one_digit_d;
    logic        blank_q, blank_d;
    logic        frame_done_q, frame_done_d;
    logic        lz_blank;

    // Next-state: the tick counter restarts on every state change.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        tcnt_d   = tcnt_q;
        boundary = 1'b0;
        if (tick) begin
            if (state_q == GUARD) begin
                if (tcnt_q == TCW'(GUARD_TICKS - 1)) begin
                    state_d = DRIVE;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end else begin
                if (tcnt_q == TCW'(ON_TICKS - 1)) begin
                    state_d  = GUARD;
                    sel_d    = sel_q + 2'd1;
                    tcnt_d   = '0;
                    boundary = (sel_q == 2'd3);
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
        end
    end

    // Valid/ready: a transfer happens on any edge where load_valid && load_ready;
    // load_ready is simply "pending buffer empty", so a commit cycle never accepts.
    always_comb begin
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (load_valid && !pend_full_q) begin
            pend_d      = load_digits;
            pend_full_d = 1'b1;
        end
        if (boundary && pend_full_q) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        case (sel_d)
            2'd3:    lz_blank = (active_d[3] == 4'd0);
            2'd2:    lz_blank = (active_d[3] == 4'd0) && (active_d[2] == 4'd0);
            2'd1:    lz_blank = (active_d[3] == 4'd0) && (active_d[2] == 4'd0)
                                && (active_d[1] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Outputs are computed from next state so they change on the same edge.
    always_comb begin
        anode_d      = (state_d == DRIVE) ? anode_pattern(sel_d) : ANODE_OFF;
        one_digit_d  = active_d[sel_d];
        blank_d      = (state_d == GUARD) || blank_mask[sel_d]
                       || (active_d[sel_d] > BCD_MAX) || lz_blank;
        frame_done_d = boundary;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= GUARD;
            sel_q        <= 2'd0;
            tcnt_q       <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            anode_q      <= ANODE_OFF;
            one_digit_q  <= 4'd0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            tcnt_q       <= tcnt_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            anode_q      <= anode_d;
            one_digit_q  <= one_digit_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready  = ~pend_full_q;
    assign anode       = anode_q;
    assign digit_sel   = sel_q;
    assign one_digit   = one_digit_q;
    assign digit_blank = blank_q;
    assign frame_done  = frame_done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: CLK_DIV=4, ON_TICKS=2, GUARD_TICKS=1 (slot 12, frame 48).
module tb_seg_scan_controller;
    import seg_pkg::*;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_digits = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        load_ready;
    logic [3:0]  anode;
    logic [1:0]  digit_sel;
    logic [3:0]  one_digit;
    logic        digit_blank;
    logic        frame_done;
    seg_state_e  dbg_state;

    seg_scan_controller #(.CLK_DIV(4), .ON_TICKS(2), .GUARD_TICKS(1)) dut (
        .clock       (clock),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_digits (load_digits),
        .blank_mask  (blank_mask),
        .anode       (anode),
        .digit_sel   (digit_sel),
        .one_digit   (one_digit),
        .digit_blank (digit_blank),
        .frame_done  (frame_done),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_vec   = 0;
    int n_bad   = 0;
    int cur_cyc = 0;
    logic [15:0] exp_q[$];
    logic [3:0]  apat[4];

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic [3:0] anode;
        logic [1:0] sel;
        logic [3:0] digit;
        logic       blank;
        logic       fd;
        logic       ready;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cur_cyc, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clock);
        @(negedge clock);
        cur_cyc++;
    endtask

    task automatic run_to(input int c);
        while (cur_cyc < c) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_valid = 1'b0;
        load_digits = 16'h0;
        blank_mask = 4'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        cur_cyc = 0;
    endtask

    task automatic load_at(input int c, input logic [15:0] d);
        run_to(c);
        load_valid = 1'b1;
        load_digits = d;
        step();
        load_valid = 1'b0;
    endtask

    // DRIVE window of digit s in frame f starts at cycle 4 + 48*f + 12*s
    task automatic check_frame(input string name, input int f);
        logic [15:0] e;
        for (int s = 0; s < 4; s++) begin
            run_to(4 + 48 * f + 12 * s + 3);
            e = exp_q.pop_front();
            check({name, "_anode"}, 16'(anode), 16'(apat[s]));
            check({name, "_digit"}, 16'(one_digit), e);
        end
    endtask

    initial begin
        apat[0] = 4'hE; apat[1] = 4'hD; apat[2] = 4'hB; apat[3] = 4'h7;
        vt[0]  = '{0,  4'h0, 4'hF, 2'd0, 4'd0, 1'b1, 1'b0, 1'b1};
        vt[1]  = '{3,  4'h0, 4'hF, 2'd0, 4'd0, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{4,  4'h0, 4'hE, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{11, 4'h0, 4'hE, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{12, 4'h0, 4'hF, 2'd1, 4'd0, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{16, 4'h2, 4'hD, 2'd1, 4'd0, LZ,   1'b0, 1'b1};
        vt[6]  = '{17, 4'h0, 4'hD, 2'd1, 4'd0, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{18, 4'h0, 4'hD, 2'd1, 4'd0, LZ,   1'b0, 1'b1};
        vt[8]  = '{24, 4'h0, 4'hF, 2'd2, 4'd0, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{28, 4'h0, 4'hB, 2'd2, 4'd0, LZ,   1'b0, 1'b1};
        vt[10] = '{40, 4'h0, 4'h7, 2'd3, 4'd0, LZ,   1'b0, 1'b1};
        vt[11] = '{47, 4'h0, 4'h7, 2'd3, 4'd0, LZ,   1'b0, 1'b1};
        vt[12] = '{48, 4'h0, 4'hF, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1};
        vt[13] = '{49, 4'h0, 4'hF, 2'd0, 4'd0, 1'b1, 1'b0, 1'b1};
        vt[14] = '{52, 4'h0, 4'hE, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        vt[15] = '{96, 4'h0, 4'hF, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1};

        // idle scan timing, live blank_mask
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_to(vt[i].cyc);
            check("idle_anode", 16'(anode), 16'(vt[i].anode));
            check("idle_sel", 16'(digit_sel), 16'(vt[i].sel));
            check("idle_digit", 16'(one_digit), 16'(vt[i].digit));
            check("idle_blank", 16'(digit_blank), 16'(vt[i].blank));
            check("idle_fd", 16'(frame_done), 16'(vt[i].fd));
            check("idle_ready", 16'(load_ready), 16'(vt[i].ready));
            blank_mask = vt[i].mask;
        end

        // single load commits at the first frame boundary
        do_reset();
        check("ld_ready0", 16'(load_ready), 16'h1);
        load_at(1, 16'h4321);
        check("ld_ready_drop", 16'(load_ready), 16'h0);
        run_to(44);
        check("ld_old_frame", 16'(one_digit), 16'h0);
        run_to(47);
        check("ld_commit_ready", 16'(load_ready), 16'h0);
        check("ld_commit_fd", 16'(frame_done), 16'h0);
        step();
        check("ld_fd", 16'(frame_done), 16'h1);
        check("ld_ready_back", 16'(load_ready), 16'h1);
        for (int s = 1; s <= 4; s++) exp_q.push_back(16'(s));
        check_frame("ld", 1);

        // back-to-back loads: second stalls until commit
        do_reset();
        load_at(1, 16'h1111);
        load_valid = 1'b1;
        load_digits = 16'h2222;
        run_to(47);
        check("b2b_stall", 16'(load_ready), 16'h0);
        step();
        check("b2b_ready48", 16'(load_ready), 16'h1);
        step();
        check("b2b_accept", 16'(load_ready), 16'h0);
        load_valid = 1'b0;
        for (int s = 0; s < 4; s++) exp_q.push_back(16'h1);
        check_frame("b2b_f1", 1);
        run_to(96);
        check("b2b_fd96", 16'(frame_done), 16'h1);
        for (int s = 0; s < 4; s++) exp_q.push_back(16'h2);
        check_frame("b2b_f2", 2);

        // blanking: mask, non-BCD, optional leading zeros
        do_reset();
        blank_mask = 4'b0010;
        load_at(1, 16'h00A5);
        run_to(52);
        check("bl_d1_val", 16'(one_digit), 16'h5);
        check("bl_d1_blank", 16'(digit_blank), 16'h0);
        run_to(64);
        check("bl_d2_val", 16'(one_digit), 16'hA);
        check("bl_d2_blank", 16'(digit_blank), 16'h1);
        run_to(76);
        check("bl_d3_blank", 16'(digit_blank), 16'(LZ));
        run_to(88);
        check("bl_d4_blank", 16'(digit_blank), 16'(LZ));
        check("bl_d4_anode", 16'(anode), 16'h7);
        run_to(98);
        blank_mask = 4'b0001;
        run_to(100);
        check("bl_mask_d1", 16'(digit_blank), 16'h1);
        run_to(104);
        blank_mask = 4'b0000;
        run_to(113);
        check("bl_nonbcd", 16'(digit_blank), 16'h1);

        // async reset mid-DRIVE of digit 2 with pending full
        do_reset();
        load_at(1, 16'h1234);
        run_to(18);
        check("rst_pre_anode", 16'(anode), 16'hD);
        check("rst_pre_ready", 16'(load_ready), 16'h0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_anode", 16'(anode), 16'hF);
        check("rst_async_ready", 16'(load_ready), 16'h1);
        check("rst_async_blank", 16'(digit_blank), 16'h1);
        check("rst_async_sel", 16'(digit_sel), 16'h0);
        @(negedge clock);
        rst = 1'b0;
        cur_cyc = 0;
        run_to(48);
        check("rst_fd", 16'(frame_done), 16'h1);
        run_to(52);
        check("rst_lost_pend", 16'(one_digit), 16'h0);

        // load held on the commit cycle transfers one cycle later
        do_reset();
        load_at(1, 16'h5678);
        run_to(47);
        check("cm_ready47", 16'(load_ready), 16'h0);
        load_valid = 1'b1;
        load_digits = 16'h9999;
        step();
        check("cm_ready48", 16'(load_ready), 16'h1);
        step();
        check("cm_ready49", 16'(load_ready), 16'h0);
        load_valid = 1'b0;
        run_to(52);
        check("cm_first", 16'(one_digit), 16'h8);
        run_to(96);
        check("cm_ready96", 16'(load_ready), 16'h1);
        run_to(100);
        check("cm_second", 16'(one_digit), 16'h9);
        check("cm_second_blank", 16'(digit_blank), 16'h0);

        // final report
        check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
